// File: rtl/fft_peak_detect_pkg.sv
// Shared defaults and FSM state encoding for the FFT peak detector slice.
// IW/LGN defaults track the fftmain output format.
package fft_peak_detect_pkg;

    localparam int DEF_IW  = 16;
    localparam int DEF_LGN = 10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/fft_peak_detect_abs_mag.sv
// Two-stage registered |re| + |im| magnitude with a valid bit travelling alongside.
// The magnitude is one bit wider than a component, so |-2^(IW-1)| needs no saturation.
module fft_abs_mag
    import fft_peak_detect_pkg::*;
#(
    parameter int IW = DEF_IW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [2*IW-1:0] data_i,
    output logic            valid_o,
    output logic [IW:0]     mag_o
);

    logic [IW-1:0] re;
    logic [IW-1:0] im;
    logic [IW-1:0] absRe_d;
    logic [IW-1:0] absIm_d;
    logic [IW-1:0] absRe_q;
    logic [IW-1:0] absIm_q;
    logic          s1Valid_q;
    logic [IW:0]   mag_q;
    logic          s2Valid_q;

    assign re = data_i[2*IW-1:IW];
    assign im = data_i[IW-1:0];

    // Two's-complement negate read as unsigned gives 2^(IW-1) for the most negative input.
    assign absRe_d = re[IW-1] ? (~re + 1'b1) : re;
    assign absIm_d = im[IW-1] ? (~im + 1'b1) : im;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            absRe_q   <= '0;
            absIm_q   <= '0;
            s1Valid_q <= 1'b0;
            mag_q     <= '0;
            s2Valid_q <= 1'b0;
        end else begin
            absRe_q   <= absRe_d;
            absIm_q   <= absIm_d;
            s1Valid_q <= valid_i;
            mag_q     <= {1'b0, absRe_q} + {1'b0, absIm_q};
            s2Valid_q <= s1Valid_q;
        end
    end

    assign valid_o = s2Valid_q;
    assign mag_o   = mag_q;

endmodule

// File: rtl/fft_peak_detect.sv
// Streaming spectral peak detector: tracks the largest |re|+|im| bin of each
// N-point frame from fftmain and reports its index and magnitude once per frame.
module fft_peak_detect
    import fft_peak_detect_pkg::*;
#(
    parameter int IW      = DEF_IW,
    parameter int LGN     = DEF_LGN,
    parameter bit SKIP_DC = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            in_sync,
    input  logic [2*IW-1:0] in_data,
    output logic [LGN-1:0]  peak_bin,
    output logic [IW:0]     peak_mag,
    output logic            peak_valid,
    output logic            frame_err
);

    state_e         state_q;
    logic [LGN-1:0] binCnt_q;
    logic           frameErr_q;
    logic           sampleOk;
    logic [LGN-1:0] sampleBin;
    logic [LGN-1:0] s1Bin_q;
    logic [LGN-1:0] s2Bin_q;
    logic           magValid;
    logic [IW:0]    mag;
    logic [IW:0]    bestMag_d;
    logic [IW:0]    bestMag_q;
    logic [LGN-1:0] bestBin_d;
    logic [LGN-1:0] bestBin_q;
    logic           lastDone_d;
    logic           lastDone_q;
    logic [LGN-1:0] peakBin_q;
    logic [IW:0]    peakMag_q;
    logic           peakValid_q;

    // A sample enters the pipeline if it starts a frame or continues one in progress.
    always_comb begin
        sampleOk  = 1'b0;
        sampleBin = in_sync ? '0 : binCnt_q;
        if (in_valid) begin
            if (state_q == ST_IDLE) sampleOk = in_sync;
            else                    sampleOk = in_sync || (binCnt_q != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            binCnt_q   <= '0;
            frameErr_q <= 1'b0;
        end else begin
            frameErr_q <= 1'b0;
            if (in_valid) begin
                if (state_q == ST_IDLE) begin
                    if (in_sync) begin
                        state_q  <= ST_ACCUM;
                        binCnt_q <= LGN'(1);
                    end
                end else if (in_sync) begin
                    frameErr_q <= (binCnt_q != '0);
                    binCnt_q   <= LGN'(1);
                end else if (binCnt_q == '0) begin
                    frameErr_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end else begin
                    binCnt_q <= binCnt_q + 1'b1;
                end
            end
        end
    end

    fft_abs_mag #(
        .IW(IW)
    ) u_abs_mag (
        .clk    (clk),
        .rst    (rst),
        .valid_i(sampleOk),
        .data_i (in_data),
        .valid_o(magValid),
        .mag_o  (mag)
    );

    // With DC skipped, bin 1 always wins against the zero seed so an all-zero frame reports bin 1.
    always_comb begin
        bestMag_d  = bestMag_q;
        bestBin_d  = bestBin_q;
        lastDone_d = 1'b0;
        if (magValid) begin
            lastDone_d = (s2Bin_q == '1);
            if (s2Bin_q == '0) begin
                bestMag_d = SKIP_DC ? '0 : mag;
                bestBin_d = '0;
            end else if ((mag > bestMag_q) || (SKIP_DC && (s2Bin_q == LGN'(1)))) begin
                bestMag_d = mag;
                bestBin_d = s2Bin_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Bin_q     <= '0;
            s2Bin_q     <= '0;
            bestMag_q   <= '0;
            bestBin_q   <= '0;
            lastDone_q  <= 1'b0;
            peakBin_q   <= '0;
            peakMag_q   <= '0;
            peakValid_q <= 1'b0;
        end else begin
            s1Bin_q     <= sampleBin;
            s2Bin_q     <= s1Bin_q;
            bestMag_q   <= bestMag_d;
            bestBin_q   <= bestBin_d;
            lastDone_q  <= lastDone_d;
            peakValid_q <= lastDone_q;
            if (lastDone_q) begin
                peakBin_q <= bestBin_q;
                peakMag_q <= bestMag_q;
            end
        end
    end

    assign peak_bin   = peakBin_q;
    assign peak_mag   = peakMag_q;
    assign peak_valid = peakValid_q;
    assign frame_err  = frameErr_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Randomised self-checking bench for fft_peak_detect (IW=8, LGN=3), running a
// SKIP_DC=0 and a SKIP_DC=1 instance side by side against an argmax reference model.
module tb_fft_peak_detect;

   localparam int IW  = 8;
   localparam int LGN = 3;
   localparam int N   = 8;

   typedef struct {int cyc; int b0; int m0; int b1; int m1;} exp_t;
   typedef struct {int cyc; int b; int m;} obs_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            inValid = 1'b0;
   logic            inSync = 1'b0;
   logic [2*IW-1:0] inData = '0;
   logic [LGN-1:0]  peakBin0, peakBin1;
   logic [IW:0]     peakMag0, peakMag1;
   logic            peakValid0, peakValid1;
   logic            frameErr0, frameErr1;

   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   feCnt0 = 0;
   int   feCnt1 = 0;
   int   lastCyc = 0;
   int   frRe[N];
   int   frIm[N];
   exp_t expQ[$];
   obs_t obs0Q[$];
   obs_t obs1Q[$];

   fft_peak_detect #(.IW(IW), .LGN(LGN), .SKIP_DC(1'b0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_sync(inSync), .in_data(inData),
      .peak_bin(peakBin0), .peak_mag(peakMag0), .peak_valid(peakValid0), .frame_err(frameErr0));

   fft_peak_detect #(.IW(IW), .LGN(LGN), .SKIP_DC(1'b1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_sync(inSync), .in_data(inData),
      .peak_bin(peakBin1), .peak_mag(peakMag1), .peak_valid(peakValid1), .frame_err(frameErr1));

   // Free-running clock and rising-edge counter used to time result pulses
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every result pulse and error pulse on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         if (peakValid0) obs0Q.push_back('{cyc, int'(peakBin0), int'(peakMag0)});
         if (peakValid1) obs1Q.push_back('{cyc, int'(peakBin1), int'(peakMag1)});
         if (frameErr0) feCnt0++;
         if (frameErr1) feCnt1++;
      end
   end

   function automatic int absI(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int randComp();
      return int'($urandom_range(255)) - 128;
   endfunction

   // Reference: plain argmax over the frame, first maximum wins; DC-skip variant searches bins 1..N-1
   function automatic void model(output int b0, output int m0, output int b1, output int m1);
      int m;
      b0 = 0; m0 = -1; b1 = 1; m1 = -1;
      for (int i = 0; i < N; i++) begin
         m = absI(frRe[i]) + absI(frIm[i]);
         if (m > m0) begin m0 = m; b0 = i; end
         if (i > 0 && m > m1) begin m1 = m; b1 = i; end
      end
   endfunction

   // Drive one input slot on the falling edge; it is accepted on the following rising edge
   task automatic applyStimulus(input bit v, input bit s, input int re, input int im);
      @(negedge clk);
      inValid = v;
      inSync  = s;
      inData  = {re[7:0], im[7:0]};
   endtask

   task automatic driveIdle(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b0, 1'($urandom_range(1)), randComp(), randComp());
   endtask

   // Send the frame held in frRe/frIm, optionally with random idle gaps, and log its expected result
   task automatic sendFrame(input int gapMax);
      exp_t e;
      for (int b = 0; b < N; b++) begin
         if (gapMax > 0) driveIdle(int'($urandom_range(gapMax)));
         applyStimulus(1'b1, b == 0, frRe[b], frIm[b]);
         if (b == N - 1) lastCyc = cyc + 4;
      end
      model(e.b0, e.m0, e.b1, e.m1);
      e.cyc = lastCyc;
      expQ.push_back(e);
   endtask

   task automatic fillFrame(input bit randomise);
      for (int i = 0; i < N; i++) begin
         frRe[i] = randomise ? randComp() : 0;
         frIm[i] = randomise ? randComp() : 0;
      end
   endtask

   task automatic clearLogs();
      @(posedge clk);
      #1;
      expQ.delete();
      obs0Q.delete();
      obs1Q.delete();
      feCnt0 = 0;
      feCnt1 = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      driveIdle(3);
      #1;
      vectors += 8;
      if (peakBin0 !== 3'd0)   begin miscompares++; $display("[TB] FAIL reset peak_bin0 got %0d want 0", peakBin0); end
      if (peakMag0 !== 9'd0)   begin miscompares++; $display("[TB] FAIL reset peak_mag0 got %0d want 0", peakMag0); end
      if (peakValid0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset peak_valid0 got %b want 0", peakValid0); end
      if (frameErr0 !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset frame_err0 got %b want 0", frameErr0); end
      if (peakBin1 !== 3'd0)   begin miscompares++; $display("[TB] FAIL reset peak_bin1 got %0d want 0", peakBin1); end
      if (peakMag1 !== 9'd0)   begin miscompares++; $display("[TB] FAIL reset peak_mag1 got %0d want 0", peakMag1); end
      if (peakValid1 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset peak_valid1 got %b want 0", peakValid1); end
      if (frameErr1 !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset frame_err1 got %b want 0", frameErr1); end
      @(negedge clk);
      rst = 1'b0;
      clearLogs();
   endtask

   // Single peak, tie, extreme value, DC-skip, all-zero and fully random frames, each isolated by idle cycles
   task automatic test_patterns();
      for (int p = 0; p < 6; p++) begin
         fillFrame(p == 2 || p == 5);
         case (p)
            0: begin frRe[5] = 40; frIm[5] = -30; end
            1: begin frRe[2] = 20; frIm[2] = -30; frRe[6] = -25; frIm[6] = 25; end
            2: begin frRe[3] = -128; frIm[3] = -128; end
            3: begin frRe[0] = 100; frIm[0] = 100; frRe[4] = 10; end
            default: ;
         endcase
         sendFrame(0);
         driveIdle(6);
      end
      vectors += 2;
      if (obs0Q.size() != expQ.size()) begin miscompares++; $display("[TB] FAIL patterns pulses0 got %0d want %0d", obs0Q.size(), expQ.size()); end
      if (obs1Q.size() != expQ.size()) begin miscompares++; $display("[TB] FAIL patterns pulses1 got %0d want %0d", obs1Q.size(), expQ.size()); end
      for (int i = 0; i < expQ.size() && i < obs0Q.size() && i < obs1Q.size(); i++) begin
         vectors += 5;
         if (obs0Q[i].cyc != expQ[i].cyc) begin miscompares++; $display("[TB] FAIL patterns[%0d] latency got cyc %0d want %0d", i, obs0Q[i].cyc, expQ[i].cyc); end
         if (obs0Q[i].b != expQ[i].b0) begin miscompares++; $display("[TB] FAIL patterns[%0d] bin0 got %0d want %0d", i, obs0Q[i].b, expQ[i].b0); end
         if (obs0Q[i].m != expQ[i].m0) begin miscompares++; $display("[TB] FAIL patterns[%0d] mag0 got %0d want %0d", i, obs0Q[i].m, expQ[i].m0); end
         if (obs1Q[i].b != expQ[i].b1) begin miscompares++; $display("[TB] FAIL patterns[%0d] bin1 got %0d want %0d", i, obs1Q[i].b, expQ[i].b1); end
         if (obs1Q[i].m != expQ[i].m1) begin miscompares++; $display("[TB] FAIL patterns[%0d] mag1 got %0d want %0d", i, obs1Q[i].m, expQ[i].m1); end
      end
      vectors += 3;
      if (feCnt0 + feCnt1 != 0) begin miscompares++; $display("[TB] FAIL patterns frame_err got %0d pulses want 0", feCnt0 + feCnt1); end
      if (int'(peakBin0) != expQ[$].b0) begin miscompares++; $display("[TB] FAIL patterns hold bin0 got %0d want %0d", peakBin0, expQ[$].b0); end
      if (int'(peakMag1) != expQ[$].m1) begin miscompares++; $display("[TB] FAIL patterns hold mag1 got %0d want %0d", peakMag1, expQ[$].m1); end
      clearLogs();
   endtask

   // Sync re-asserted at bin 4 aborts the partial frame; the sync sample starts the reported frame
   task automatic test_early_sync();
      for (int b = 0; b < 4; b++)
         applyStimulus(1'b1, b == 0, (b == 2) ? -128 : randComp(), (b == 2) ? -128 : randComp());
      fillFrame(1'b1);
      sendFrame(0);
      driveIdle(6);
      vectors += 4;
      if (obs0Q.size() != 1) begin miscompares++; $display("[TB] FAIL early_sync pulses0 got %0d want 1", obs0Q.size()); end
      if (obs1Q.size() != 1) begin miscompares++; $display("[TB] FAIL early_sync pulses1 got %0d want 1", obs1Q.size()); end
      if (feCnt0 != 1) begin miscompares++; $display("[TB] FAIL early_sync frame_err0 got %0d pulses want 1", feCnt0); end
      if (feCnt1 != 1) begin miscompares++; $display("[TB] FAIL early_sync frame_err1 got %0d pulses want 1", feCnt1); end
      for (int i = 0; i < 1 && i < obs0Q.size() && i < obs1Q.size(); i++) begin
         vectors += 5;
         if (obs0Q[i].cyc != expQ[i].cyc) begin miscompares++; $display("[TB] FAIL early_sync latency got cyc %0d want %0d", obs0Q[i].cyc, expQ[i].cyc); end
         if (obs0Q[i].b != expQ[i].b0) begin miscompares++; $display("[TB] FAIL early_sync bin0 got %0d want %0d", obs0Q[i].b, expQ[i].b0); end
         if (obs0Q[i].m != expQ[i].m0) begin miscompares++; $display("[TB] FAIL early_sync mag0 got %0d want %0d", obs0Q[i].m, expQ[i].m0); end
         if (obs1Q[i].b != expQ[i].b1) begin miscompares++; $display("[TB] FAIL early_sync bin1 got %0d want %0d", obs1Q[i].b, expQ[i].b1); end
         if (obs1Q[i].m != expQ[i].m1) begin miscompares++; $display("[TB] FAIL early_sync mag1 got %0d want %0d", obs1Q[i].m, expQ[i].m1); end
      end
      clearLogs();
   endtask

   // Two gapless frames followed by a third with random input gaps
   task automatic test_back_to_back();
      for (int f = 0; f < 3; f++) begin
         fillFrame(1'b1);
         sendFrame((f == 2) ? 3 : 0);
      end
      driveIdle(6);
      vectors += 3;
      if (obs0Q.size() != 3) begin miscompares++; $display("[TB] FAIL back_to_back pulses0 got %0d want 3", obs0Q.size()); end
      if (obs1Q.size() != 3) begin miscompares++; $display("[TB] FAIL back_to_back pulses1 got %0d want 3", obs1Q.size()); end
      if (feCnt0 + feCnt1 != 0) begin miscompares++; $display("[TB] FAIL back_to_back frame_err got %0d pulses want 0", feCnt0 + feCnt1); end
      for (int i = 0; i < expQ.size() && i < obs0Q.size() && i < obs1Q.size(); i++) begin
         vectors += 5;
         if (obs0Q[i].cyc != expQ[i].cyc) begin miscompares++; $display("[TB] FAIL back_to_back[%0d] latency got cyc %0d want %0d", i, obs0Q[i].cyc, expQ[i].cyc); end
         if (obs0Q[i].b != expQ[i].b0) begin miscompares++; $display("[TB] FAIL back_to_back[%0d] bin0 got %0d want %0d", i, obs0Q[i].b, expQ[i].b0); end
         if (obs0Q[i].m != expQ[i].m0) begin miscompares++; $display("[TB] FAIL back_to_back[%0d] mag0 got %0d want %0d", i, obs0Q[i].m, expQ[i].m0); end
         if (obs1Q[i].b != expQ[i].b1) begin miscompares++; $display("[TB] FAIL back_to_back[%0d] bin1 got %0d want %0d", i, obs1Q[i].b, expQ[i].b1); end
         if (obs1Q[i].m != expQ[i].m1) begin miscompares++; $display("[TB] FAIL back_to_back[%0d] mag1 got %0d want %0d", i, obs1Q[i].m, expQ[i].m1); end
      end
      clearLogs();
   endtask

   // A non-sync sample where bin 0 is due raises one error; further non-sync samples are ignored in IDLE
   task automatic test_missing_sync();
      fillFrame(1'b1);
      sendFrame(0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 127, 127);
      fillFrame(1'b1);
      frRe[2] = 50; frIm[2] = 50;
      sendFrame(1);
      driveIdle(6);
      vectors += 4;
      if (obs0Q.size() != 2) begin miscompares++; $display("[TB] FAIL missing_sync pulses0 got %0d want 2", obs0Q.size()); end
      if (obs1Q.size() != 2) begin miscompares++; $display("[TB] FAIL missing_sync pulses1 got %0d want 2", obs1Q.size()); end
      if (feCnt0 != 1) begin miscompares++; $display("[TB] FAIL missing_sync frame_err0 got %0d pulses want 1", feCnt0); end
      if (feCnt1 != 1) begin miscompares++; $display("[TB] FAIL missing_sync frame_err1 got %0d pulses want 1", feCnt1); end
      for (int i = 0; i < expQ.size() && i < obs0Q.size() && i < obs1Q.size(); i++) begin
         vectors += 4;
         if (obs0Q[i].b != expQ[i].b0) begin miscompares++; $display("[TB] FAIL missing_sync[%0d] bin0 got %0d want %0d", i, obs0Q[i].b, expQ[i].b0); end
         if (obs0Q[i].m != expQ[i].m0) begin miscompares++; $display("[TB] FAIL missing_sync[%0d] mag0 got %0d want %0d", i, obs0Q[i].m, expQ[i].m0); end
         if (obs1Q[i].b != expQ[i].b1) begin miscompares++; $display("[TB] FAIL missing_sync[%0d] bin1 got %0d want %0d", i, obs1Q[i].b, expQ[i].b1); end
         if (obs1Q[i].m != expQ[i].m1) begin miscompares++; $display("[TB] FAIL missing_sync[%0d] mag1 got %0d want %0d", i, obs1Q[i].m, expQ[i].m1); end
      end
      clearLogs();
   endtask

   // Reset at bin 3 clears outputs at once; nothing is reported until a complete synced frame follows
   task automatic test_reset_midframe();
      for (int b = 0; b < 4; b++) applyStimulus(1'b1, b == 0, randComp(), randComp());
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      vectors += 4;
      if (peakMag0 !== 9'd0) begin miscompares++; $display("[TB] FAIL reset_mid peak_mag0 got %0d want 0", peakMag0); end
      if (peakBin1 !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_mid peak_bin1 got %0d want 0", peakBin1); end
      if (peakMag1 !== 9'd0) begin miscompares++; $display("[TB] FAIL reset_mid peak_mag1 got %0d want 0", peakMag1); end
      if (peakValid0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mid peak_valid0 got %b want 0", peakValid0); end
      driveIdle(2);
      rst = 1'b0;
      clearLogs();
      for (int b = 4; b < N; b++) applyStimulus(1'b1, 1'b0, randComp(), randComp());
      fillFrame(1'b1);
      sendFrame(2);
      driveIdle(6);
      vectors += 3;
      if (obs0Q.size() != 1) begin miscompares++; $display("[TB] FAIL reset_mid pulses0 got %0d want 1", obs0Q.size()); end
      if (feCnt0 + feCnt1 != 0) begin miscompares++; $display("[TB] FAIL reset_mid frame_err got %0d pulses want 0", feCnt0 + feCnt1); end
      if (obs1Q.size() != 1) begin miscompares++; $display("[TB] FAIL reset_mid pulses1 got %0d want 1", obs1Q.size()); end
      for (int i = 0; i < 1 && i < obs0Q.size() && i < obs1Q.size(); i++) begin
         vectors += 3;
         if (obs0Q[i].cyc != expQ[i].cyc) begin miscompares++; $display("[TB] FAIL reset_mid latency got cyc %0d want %0d", obs0Q[i].cyc, expQ[i].cyc); end
         if (obs0Q[i].b != expQ[i].b0) begin miscompares++; $display("[TB] FAIL reset_mid bin0 got %0d want %0d", obs0Q[i].b, expQ[i].b0); end
         if (obs1Q[i].m != expQ[i].m1) begin miscompares++; $display("[TB] FAIL reset_mid mag1 got %0d want %0d", obs1Q[i].m, expQ[i].m1); end
      end
      clearLogs();
   endtask

   initial begin
      test_reset();
      test_patterns();
      test_early_sync();
      test_back_to_back();
      test_missing_sync();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
